// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline encodings and the ID/EX register layout
package mips_pkg;

  // ALU function encodings
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLLV = 4'b1011;
  localparam logic [3:0] ALU_SRLV = 4'b1100;
  localparam logic [3:0] ALU_SRAV = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;

  // Forwarding-source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Architectural zero register; never a forwarding target
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rs;
    logic        uses_rt;
    logic [3:0]  func;
    logic [4:0]  shamt;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } id_ex_t;

  // A bubble is the all-zero register image
  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - picks the forwarding source for one EX-stage operand
module fwd_sel
  import mips_pkg::*;
(
  input  logic [4:0] spec,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_rd,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel
);

  // EX/MEM is the younger producer, so it is checked before MEM/WB
  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd != REG_ZERO) && (mem_rd == spec)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != REG_ZERO) && (wb_rd == spec)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and operand forwarding
module id_ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [3:0]  id_alu_func,
  input  logic [4:0]  id_shamt,
  input  logic        id_alu_src,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        flush,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic        stall,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_func,
  output logic [4:0]  alu_shamt,
  output logic [31:0] ex_store_data,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic [4:0]  ex_rd
);

  id_ex_t      pipe_q;
  id_ex_t      pipe_d;
  logic [1:0]  rs_sel;
  logic [1:0]  rt_sel;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  // The source-use flags travel with the instruction but EX does not consume them
  logic unused_uses;
  assign unused_uses = pipe_q.uses_rs ^ pipe_q.uses_rt;

  // Load-use hazard: a load in EX whose destination ID is about to read; a flush cancels it
  always_comb begin
    stall = 1'b0;
    if (id_valid && pipe_q.valid && pipe_q.mem_read && (pipe_q.rd != REG_ZERO) && !flush) begin
      if ((id_uses_rs && (pipe_q.rd == id_rs)) || (id_uses_rt && (pipe_q.rd == id_rt))) begin
        stall = 1'b1;
      end
    end
  end

  // Next register contents: flush beats stall, both insert a bubble
  always_comb begin
    pipe_d = ID_EX_BUBBLE;
    if (!flush && !stall) begin
      pipe_d.valid      = id_valid;
      pipe_d.rs_data    = id_rs_data;
      pipe_d.rt_data    = id_rt_data;
      pipe_d.imm        = id_imm;
      pipe_d.rs         = id_rs;
      pipe_d.rt         = id_rt;
      pipe_d.rd         = id_rd;
      pipe_d.uses_rs    = id_uses_rs;
      pipe_d.uses_rt    = id_uses_rt;
      pipe_d.func       = id_alu_func;
      pipe_d.shamt      = id_shamt;
      pipe_d.alu_src    = id_alu_src;
      pipe_d.reg_write  = id_reg_write;
      pipe_d.mem_read   = id_mem_read;
      pipe_d.mem_write  = id_mem_write;
      pipe_d.mem_to_reg = id_mem_to_reg;
    end
  end

  // ID/EX register; reset empties the stage immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= ID_EX_BUBBLE;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  fwd_sel u_fwd_rs (
    .spec          (pipe_q.rs),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .sel           (rs_sel)
  );

  fwd_sel u_fwd_rt (
    .spec          (pipe_q.rt),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .sel           (rt_sel)
  );

  // Forwarding muxes for both source operands
  always_comb begin
    rs_fwd = pipe_q.rs_data;
    rt_fwd = pipe_q.rt_data;
    case (rs_sel)
      FWD_MEM: rs_fwd = mem_result;
      FWD_WB:  rs_fwd = wb_result;
      default: rs_fwd = pipe_q.rs_data;
    endcase
    case (rt_sel)
      FWD_MEM: rt_fwd = mem_result;
      FWD_WB:  rt_fwd = wb_result;
      default: rt_fwd = pipe_q.rt_data;
    endcase
  end

  // ALU operand selection; stores always see the forwarded rt value
  always_comb begin
    alu_a         = rs_fwd;
    alu_b         = pipe_q.alu_src ? pipe_q.imm : rt_fwd;
    ex_store_data = rt_fwd;
  end

  assign alu_func      = pipe_q.func;
  assign alu_shamt     = pipe_q.shamt;
  assign ex_valid      = pipe_q.valid;
  assign ex_reg_write  = pipe_q.reg_write;
  assign ex_mem_read   = pipe_q.mem_read;
  assign ex_mem_write  = pipe_q.mem_write;
  assign ex_mem_to_reg = pipe_q.mem_to_reg;
  assign ex_rd         = pipe_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for the ID/EX stage
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        uses_rs;
    logic        uses_rt;
    logic [3:0]  func;
    logic [4:0]  shamt;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } instr_t;

  typedef struct packed {
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wres;
  } fwd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_rs_data = '0;
  logic [31:0] id_rt_data = '0;
  logic [31:0] id_imm = '0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic [4:0]  id_rd = '0;
  logic        id_uses_rs = 1'b0;
  logic        id_uses_rt = 1'b0;
  logic [3:0]  id_alu_func = '0;
  logic [4:0]  id_shamt = '0;
  logic        id_alu_src = 1'b0;
  logic        id_reg_write = 1'b0;
  logic        id_mem_read = 1'b0;
  logic        id_mem_write = 1'b0;
  logic        id_mem_to_reg = 1'b0;
  logic        flush = 1'b0;
  logic        mem_reg_write = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_result = '0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_result = '0;
  logic        stall;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_func;
  logic [4:0]  alu_shamt;
  logic [31:0] ex_store_data;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic [4:0]  ex_rd;

  int total = 0;
  int bad = 0;
  instr_t exp_q[$];
  instr_t cur = '0;

  id_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_alu_func   (id_alu_func),
    .id_shamt      (id_shamt),
    .id_alu_src    (id_alu_src),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .id_mem_write  (id_mem_write),
    .id_mem_to_reg (id_mem_to_reg),
    .flush         (flush),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .stall         (stall),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_func      (alu_func),
    .alu_shamt     (alu_shamt),
    .ex_store_data (ex_store_data),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_rd         (ex_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd_model(input logic [4:0] r, input logic [31:0] rf, input fwd_t f);
    if (f.mwe && f.mrd != 5'd0 && f.mrd == r) return f.mres;
    if (f.wwe && f.wrd != 5'd0 && f.wrd == r) return f.wres;
    return rf;
  endfunction

  function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic [31:0] imm, input logic urs, input logic urt,
                                input logic [3:0] fn, input logic [4:0] sh, input logic src,
                                input logic rw, input logic mr, input logic mw, input logic m2r);
    instr_t i;
    i.valid = v; i.rs = rs; i.rt = rt; i.rd = rd;
    i.rs_data = rsd; i.rt_data = rtd; i.imm = imm;
    i.uses_rs = urs; i.uses_rt = urt; i.func = fn; i.shamt = sh;
    i.alu_src = src; i.reg_write = rw; i.mem_read = mr; i.mem_write = mw; i.mem_to_reg = m2r;
    return i;
  endfunction

  function automatic fwd_t mkf(input logic mwe, input logic [4:0] mrd, input logic [31:0] mres,
                               input logic wwe, input logic [4:0] wrd, input logic [31:0] wres);
    fwd_t f;
    f.mwe = mwe; f.mrd = mrd; f.mres = mres; f.wwe = wwe; f.wrd = wrd; f.wres = wres;
    return f;
  endfunction

  task automatic drive(input instr_t i, input logic fl, input fwd_t f);
    id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_rs_data = i.rs_data; id_rt_data = i.rt_data; id_imm = i.imm;
    id_uses_rs = i.uses_rs; id_uses_rt = i.uses_rt; id_alu_func = i.func; id_shamt = i.shamt;
    id_alu_src = i.alu_src; id_reg_write = i.reg_write; id_mem_read = i.mem_read;
    id_mem_write = i.mem_write; id_mem_to_reg = i.mem_to_reg;
    flush = fl;
    mem_reg_write = f.mwe; mem_rd = f.mrd; mem_result = f.mres;
    wb_reg_write = f.wwe; wb_rd = f.wrd; wb_result = f.wres;
  endtask

  // One clock: f feeds the instruction now in EX, i/fl are offered for capture at the next edge
  task automatic cycle(input instr_t i, input logic fl, input fwd_t f, output logic st);
    logic exp_st;
    @(negedge clk);
    drive(i, fl, f);
    #1;
    cur = (exp_q.size() != 0) ? exp_q.pop_front() : instr_t'('0);
    check_eq("ex_valid", ex_valid, cur.valid);
    check_eq("ex_reg_write", ex_reg_write, cur.reg_write);
    check_eq("ex_mem_read", ex_mem_read, cur.mem_read);
    check_eq("ex_mem_write", ex_mem_write, cur.mem_write);
    check_eq("ex_mem_to_reg", ex_mem_to_reg, cur.mem_to_reg);
    check_eq("ex_rd", ex_rd, cur.rd);
    check_eq("alu_func", alu_func, cur.func);
    check_eq("alu_shamt", alu_shamt, cur.shamt);
    check_eq("alu_a", alu_a, fwd_model(cur.rs, cur.rs_data, f));
    check_eq("alu_b", alu_b, cur.alu_src ? cur.imm : fwd_model(cur.rt, cur.rt_data, f));
    check_eq("store_data", ex_store_data, fwd_model(cur.rt, cur.rt_data, f));
    exp_st = i.valid & cur.valid & cur.mem_read & (cur.rd != 5'd0) &
             ((i.uses_rs & (cur.rd == i.rs)) | (i.uses_rt & (cur.rd == i.rt))) & ~fl;
    check_eq("stall", stall, exp_st);
    exp_q.push_back((fl || exp_st) ? instr_t'('0) : i);
    st = exp_st;
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i.valid = ($urandom_range(0, 7) != 0);
    i.rs = 5'($urandom_range(0, 3)); i.rt = 5'($urandom_range(0, 3)); i.rd = 5'($urandom_range(0, 3));
    i.rs_data = $urandom; i.rt_data = $urandom; i.imm = $urandom;
    i.uses_rs = 1'($urandom_range(0, 1)); i.uses_rt = 1'($urandom_range(0, 1));
    i.func = 4'($urandom_range(0, 14)); i.shamt = 5'($urandom_range(0, 31));
    i.alu_src = 1'($urandom_range(0, 1)); i.reg_write = 1'($urandom_range(0, 1));
    i.mem_read = ($urandom_range(0, 2) == 0); i.mem_write = 1'($urandom_range(0, 1));
    i.mem_to_reg = 1'($urandom_range(0, 1));
    return i;
  endfunction

  function automatic fwd_t rand_fwd();
    return mkf(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_ex_valid"}, ex_valid, 1'b0);
    check_eq({pfx, "_ctrl"}, {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 4'b0);
    check_eq({pfx, "_ex_rd"}, ex_rd, 5'd0);
    check_eq({pfx, "_func_shamt"}, {alu_func, alu_shamt}, 9'd0);
    check_eq({pfx, "_alu_a"}, alu_a, 32'd0);
    check_eq({pfx, "_alu_b"}, alu_b, 32'd0);
    check_eq({pfx, "_store"}, ex_store_data, 32'd0);
    check_eq({pfx, "_stall"}, stall, 1'b0);
  endtask

  instr_t idle, add3, or4, lw5, sub6, lw7, use7, addi9, held;
  fwd_t   nf, f55, fr0, fwb, fst;
  logic   st;
  logic   fl;

  initial begin
    idle  = '0;
    nf    = '0;
    add3  = mk(1, 1, 2, 3, 32'hA, 32'hB, 32'h0, 1, 1, 4'b0000, 5'd0, 0, 1, 0, 0, 0);
    or4   = mk(1, 0, 2, 4, 32'h0, 32'h7, 32'h0, 1, 1, 4'b0011, 5'd0, 0, 1, 0, 0, 0);
    lw5   = mk(1, 1, 5, 5, 32'h100, 32'h0, 32'h8, 1, 0, 4'b0000, 5'd0, 1, 1, 1, 0, 1);
    sub6  = mk(1, 4, 5, 6, 32'h20, 32'hDEAD, 32'h0, 1, 1, 4'b0001, 5'd0, 0, 1, 0, 0, 0);
    lw7   = mk(1, 1, 7, 7, 32'h200, 32'h0, 32'h4, 1, 0, 4'b0000, 5'd0, 1, 1, 1, 0, 1);
    use7  = mk(1, 7, 2, 8, 32'h0, 32'h0, 32'h0, 1, 0, 4'b1000, 5'd3, 0, 1, 0, 0, 0);
    addi9 = mk(1, 8, 9, 9, 32'h3, 32'h4, 32'hFFFF_FFFC, 1, 0, 4'b0000, 5'd0, 1, 1, 0, 0, 0);
    f55   = mkf(1, 5'd1, 32'h55, 1, 5'd1, 32'h11);
    fr0   = mkf(1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'h0);
    fwb   = mkf(0, 5'd0, 32'h0, 1, 5'd5, 32'h1234);
    fst   = mkf(1, 5'd9, 32'hCAFE_BABE, 1, 5'd8, 32'h77);

    drive(idle, 0, nf);
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    cycle(add3, 0, nf, st);
    cycle(or4, 0, f55, st);
    check_eq("fwd_mem_prio", alu_a, 32'h55);
    cycle(lw5, 0, fr0, st);
    check_eq("r0_guard", alu_a, 32'h0);
    cycle(sub6, 0, nf, st);
    check_eq("lu_stall", stall, 1'b1);
    cycle(sub6, 0, nf, st);
    check_eq("lu_bubble", ex_valid, 1'b0);
    check_eq("lu_stall_drop", stall, 1'b0);
    cycle(lw7, 0, fwb, st);
    check_eq("lu_wb_fwd", alu_b, 32'h1234);
    cycle(use7, 1, nf, st);
    check_eq("flush_no_stall", stall, 1'b0);
    cycle(addi9, 0, nf, st);
    check_eq("flush_bubble", ex_valid, 1'b0);
    cycle(idle, 0, fst, st);
    check_eq("imm_alu_b", alu_b, 32'hFFFF_FFFC);
    check_eq("imm_store", ex_store_data, 32'hCAFE_BABE);
    check_eq("imm_alu_a", alu_a, 32'h77);

    st = 1'b0;
    held = '0;
    for (int n = 0; n < 80; n++) begin
      if (!st) held = rand_instr();
      fl = ($urandom_range(0, 9) == 0);
      cycle(held, fl, rand_fwd(), st);
    end

    cycle(idle, 0, nf, st);
    cycle(add3, 0, nf, st);
    @(posedge clk);
    #2;
    check_eq("pre_rst_valid", ex_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_q.delete();
    drive(idle, 0, nf);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(lw5, 0, nf, st);
    cycle(sub6, 0, nf, st);
    check_eq("post_rst_first", ex_valid, 1'b1);
    check_eq("post_rst_stall", stall, 1'b1);
    cycle(sub6, 0, nf, st);
    cycle(idle, 0, fwb, st);
    check_eq("post_rst_fwd", alu_b, 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage MIPS pipeline, sitting directly upstream of the EX-stage ALU. It does four things:
- captures decoded operands and controls from ID;
- detects load-use hazards and stalls ID/IF;
- inserts bubbles on stall or flush;
- drives the ALU's `a`, `b`, `func` and `shamt` inputs through an operand-forwarding network fed by the EX/MEM and MEM/WB stages.

## Interface
- No parameters; datapath fixed at 32 bits, register specifiers at 5 bits.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs_data`, `id_rt_data` in 32: register-file read data.
- `id_imm` in 32: immediate, already extended by ID.
- `id_rs`, `id_rt`, `id_rd` in 5: source specifiers; `id_rd` is the chosen destination.
- `id_uses_rs`, `id_uses_rt` in 1: instruction actually reads rs / rt.
- `id_alu_func` in 4: ALU opcode, ALU encoding.
- `id_shamt` in 5: shift amount.
- `id_alu_src` in 1: 1 selects `id_imm` for `alu_b`.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1: downstream controls.
- `flush` in 1: kill the instruction entering EX (branch/jump redirect).
- `mem_reg_write` in 1, `mem_rd` in 5, `mem_result` in 32: EX/MEM forwarding source.
- `wb_reg_write` in 1, `wb_rd` in 5, `wb_result` in 32: MEM/WB forwarding source.
- `stall` out 1: hold PC and IF/ID this cycle.
- `alu_a`, `alu_b` out 32: forwarded ALU operands.
- `alu_func` out 4, `alu_shamt` out 5: to ALU.
- `ex_store_data` out 32: forwarded rt value for stores.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out 1: registered controls.
- `ex_rd` out 5: registered destination.

## Operation
- **Pipeline register.** Stores valid, rs/rt data, imm, rs, rt, rd, uses_rs, uses_rt, func, shamt, alu_src and the four controls.
- **Load-use hazard:**
  - `stall` = `id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)) & ~flush`.
  - Combinational from ID inputs and registered EX state.
- **Capture.** At each rising edge the register loads one of the following, in priority order:
  - `flush`=1: bubble.
  - else `stall`=1: bubble; ID inputs are held upstream and re-presented.
  - else: the ID fields, with `ex_valid`=`id_valid`.
- **Bubble.** valid=0; all five control outputs 0; func=0, shamt=0, rd/rs/rt=0; data fields 0.
- **Forwarding.** Applied independently per source (rs, rt), using the registered specifier:
  - EX/MEM if `mem_reg_write & mem_rd!=0 & mem_rd==spec`;
  - else MEM/WB if `wb_reg_write & wb_rd!=0 & wb_rd==spec`;
  - else the registered register-file data.
  - EX/MEM always wins over MEM/WB.
  - Register 0 never forwards.
- **Operand outputs:**
  - `alu_a` = forwarded rs.
  - `ex_store_data` = forwarded rt.
  - `alu_b` = registered imm if alu_src, else forwarded rt.
  - `alu_func`/`alu_shamt` = registered fields.
- **Controls.** `ex_*` controls and `ex_rd` are driven straight from the register.

## Timing
- **Reset.** Asynchronous assertion clears every register. While `rst_n`=0 the outputs are:
  - `ex_valid`, all `ex_*` controls, `ex_rd`, `alu_func`, `alu_shamt` = 0;
  - `alu_a`, `alu_b`, `ex_store_data` = 0, unless a forwarding source matches, which it cannot because rd=0;
  - `stall` = 0.
- **Reset release.** Takes effect at the next rising edge.
- **Latency.** One cycle from ID inputs to `ex_*`/ALU outputs.
- **Forwarding path.** Combinational, same cycle as the EX/MEM and MEM/WB inputs.
- **Stall duration.** `stall` lasts exactly one cycle per load-use pair. The bubble clears `ex_mem_read`, so `stall` drops in the next cycle, and the dependent instruction then receives the load value from MEM/WB.
- **Flush and stall together.** Flush wins; `stall` is forced to 0.
- **Reset mid-stall.** Pipeline empties; no stale bubble or instruction survives.

## Structure
- Shared package/include `mips_pkg` holds:
  - ALU func encodings (ADD 4'b0000 … SRAV 4'b1101, LUI 4'b1110);
  - forwarding-select constants `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10;
  - `REG_ZERO`=5'd0.
- One sub-module, `fwd_sel`: takes a specifier plus the two forwarding sources and returns a 2-bit select. Instantiated twice, for rs and rt.
- The hazard logic, pipeline register and operand muxes stay in `id_ex_stage`.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-run with `ex_valid`=1 → all `ex_*` outputs 0 immediately, `stall`=0; after release, first captured instruction appears one edge later.
- **EX/MEM forwarding.** ADD r3 (func 0000, rs=r1) in EX with `mem_rd`=1, `mem_result`=0x0000_0055, `wb_rd`=1, `wb_result`=0x11 → `alu_a`=0x55 (MEM priority).
- **Register-0 guard.** rs=r0, `mem_rd`=0, `mem_reg_write`=1, `mem_result`=0xFFFF_FFFF → `alu_a`=0 (register-file value).
- **Load-use stall.** LW r5 in EX, ID presents SUB using rt=r5 → `stall`=1 for one cycle, bubble in EX (`ex_valid`=0); next cycle SUB captured, `alu_b` takes `wb_result`=0x1234.
- **Flush priority.** `flush`=1 in the same cycle as a load-use match → `stall`=0, next edge EX holds a bubble.
- **Immediate select.** ADDI `alu_src`=1, `id_imm`=0xFFFF_FFFC, rt forward active → `alu_b`=0xFFFF_FFFC, `ex_store_data`=forwarded rt value.
